// File: rtl/sti_res_loader.sv
// sti_res_loader: expands a 1024 x 16-bit bitmap ROM into a 128 x 128 byte-per-pixel RAM image.
// Build option BORDER_ZERO_EN forces the outer ring of pixels (row/col 0 or 127) to background.
module sti_res_loader (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        hold_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        sti_rd_o,
    output logic [9:0]  sti_addr_o,
    input  logic [15:0] sti_di_i,
    output logic        res_wr_o,
    output logic [13:0] res_addr_o,
    output logic [7:0]  res_do_o,
    output logic [14:0] fg_cnt_o
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | one ROM read of word sti_addr
    // WRITE | 16 pixel writes of the latched word, MSB first
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  sti_addr_q, sti_addr_d;
    logic [3:0]  k_q, k_d;
    logic [15:0] sh_q, sh_d;
    logic [14:0] fg_q, fg_d;
    logic        pix;
    logic        busy, done, sti_rd, res_wr;

`ifdef BORDER_ZERO_EN
    logic [6:0] row;
    logic [6:0] col;
    logic       on_border;

    assign row       = sti_addr_q[9:3];
    assign col       = {sti_addr_q[2:0], k_q};
    assign on_border = (row == 7'd0) || (row == 7'd127) || (col == 7'd0) || (col == 7'd127);
    assign pix       = sh_q[15] & ~on_border;
`else
    assign pix       = sh_q[15];
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            sti_addr_q <= 10'd0;
            k_q        <= 4'd0;
            sh_q       <= 16'd0;
            fg_q       <= 15'd0;
        end else begin
            state_q    <= state_d;
            sti_addr_q <= sti_addr_d;
            k_q        <= k_d;
            sh_q       <= sh_d;
            fg_q       <= fg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sti_addr_d = sti_addr_q;
        k_d        = k_q;
        sh_d       = sh_q;
        fg_d       = fg_q;
        busy       = 1'b0;
        done       = 1'b0;
        sti_rd     = 1'b0;
        res_wr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = FETCH;
                    sti_addr_d = 10'd0;
                    k_d        = 4'd0;
                    fg_d       = 15'd0;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (!hold_i) begin
                    // ROM data for this read is valid at the edge closing this cycle
                    sti_rd  = 1'b1;
                    sh_d    = sti_di_i;
                    k_d     = 4'd0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                busy = 1'b1;
                if (!hold_i) begin
                    res_wr = 1'b1;
                    sh_d   = {sh_q[14:0], 1'b0};
                    k_d    = k_q + 4'd1;
                    if (pix) begin
                        fg_d = fg_q + 15'd1;
                    end
                    if (k_q == 4'd15) begin
                        if (sti_addr_q == 10'd1023) begin
                            state_d = DONE;
                        end else begin
                            sti_addr_d = sti_addr_q + 10'd1;
                            state_d    = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o     = busy;
    assign done_o     = done;
    assign sti_rd_o   = sti_rd;
    assign res_wr_o   = res_wr;
    assign sti_addr_o = sti_addr_q;
    assign res_addr_o = {sti_addr_q, k_q};
    assign res_do_o   = (state_q == WRITE) ? {7'd0, pix} : 8'h00;
    assign fg_cnt_o   = fg_q;

endmodule
